// File: rtl/pipelined_cla_adder_if.sv
// Stream interface for pipelined_cla_adder: operand beat in, result beat out.
// master drives operands and out_ready; slave is the adder.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor: one BLOCK-bit lookahead group per stage, group carry registered.
// Define PIPELINED_CLA_OVF_EN to pipeline the signed-overflow flag; otherwise ovf is tied to 0.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic                  clk,
  input logic                  rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int NSTAGE = (BLOCK > 0) ? WIDTH / BLOCK : 1;

  if ((BLOCK < 1) || (BLOCK > WIDTH) ||
      ((WIDTH % ((BLOCK > 0) ? BLOCK : 1)) != 0)) begin : g_bad_cfg
    $error("pipelined_cla_adder: WIDTH must be a positive multiple of BLOCK");
  end

  // A result held at the output freezes every stage; bubbles are kept as-is.
  logic en;
  assign en           = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = en;

  for (genvar k = 0; k < NSTAGE; k++) begin : stg
    localparam int LO = k * BLOCK;
    localparam int HI = LO + BLOCK;

    logic [WIDTH-1:LO] a_i;
    logic [WIDTH-1:LO] b_i;
    logic              c_i;
    logic              v_i;
    logic [BLOCK-1:0]  g;
    logic [BLOCK-1:0]  p;
    logic [BLOCK:0]    cy;
    logic [BLOCK-1:0]  gs;
    logic [HI-1:0]     s_n;
    logic              v_q;
    logic              c_q;
    logic [HI-1:0]     s_q;

    if (k == 0) begin : g_in
      assign a_i = bus.a;
      assign b_i = bus.sub ? ~bus.b : bus.b;
      assign c_i = bus.sub | bus.cin;
      assign v_i = bus.in_valid;
    end else begin : g_in
      assign a_i = stg[k-1].g_op.a_q;
      assign b_i = stg[k-1].g_op.b_q;
      assign c_i = stg[k-1].c_q;
      assign v_i = stg[k-1].v_q;
    end

    assign g = a_i[HI-1:LO] & b_i[HI-1:LO];
    assign p = a_i[HI-1:LO] ^ b_i[HI-1:LO];

    // cy[i] = c_i&p[0..i-1] | OR_j g[j]&p[j+1..i-1]; each product built independently.
    always_comb begin : la
      logic t;
      // NOTE: everything written here is defaulted first, so no path can infer a latch.
      t  = 1'b0;
      cy = '0;
      for (int i = 0; i <= BLOCK; i++) begin
        t = c_i;
        for (int m = 0; m < i; m++) t = t & p[m];
        cy[i] = t;
        for (int j = 0; j < i; j++) begin
          t = g[j];
          for (int m = j + 1; m < i; m++) t = t & p[m];
          cy[i] = cy[i] | t;
        end
      end
    end

    assign gs = p ^ cy[BLOCK-1:0];

    if (k == 0) begin : g_sn
      assign s_n = gs;
    end else begin : g_sn
      assign s_n = {gs, stg[k-1].s_q};
    end

    // NOTE: data registers are reset along with valid so no X ever reaches sum/cout.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (en) begin
        v_q <= v_i;
        c_q <= cy[BLOCK];
        s_q <= s_n;
      end
    end

    // Upper operand bits ride along until their group's stage.
    if (k < NSTAGE - 1) begin : g_op
      logic [WIDTH-1:HI] a_q;
      logic [WIDTH-1:HI] b_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_i[WIDTH-1:HI];
          b_q <= b_i[WIDTH-1:HI];
        end
      end
    end

`ifdef PIPELINED_CLA_OVF_EN
    if (k == NSTAGE - 1) begin : g_ov
      logic ov_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)     ov_q <= 1'b0;
        else if (en) ov_q <= cy[BLOCK] ^ cy[BLOCK-1];
      end
    end
`endif
  end

  assign bus.out_valid = stg[NSTAGE-1].v_q;
  assign bus.sum       = stg[NSTAGE-1].s_q;
  assign bus.cout      = stg[NSTAGE-1].c_q;
`ifdef PIPELINED_CLA_OVF_EN
  assign bus.ovf       = stg[NSTAGE-1].g_ov.ov_q;
`else
  assign bus.ovf       = 1'b0;
`endif
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Directed bench for pipelined_cla_adder: a 16/4 instance (4 stages) and an 8/8 instance (1 stage).
// Expected ovf follows PIPELINED_CLA_OVF_EN.
module tb_pipelined_cla_adder;
  logic clk;
  logic rst;
  int   total = 0;
  int   bad   = 0;

`ifdef PIPELINED_CLA_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  pipelined_cla_adder_if #(.WIDTH(16)) b16 ();
  pipelined_cla_adder_if #(.WIDTH(8))  b8 ();

  pipelined_cla_adder #(.WIDTH(16), .BLOCK(4)) u_dut16 (.clk(clk), .rst(rst), .bus(b16));
  pipelined_cla_adder #(.WIDTH(8),  .BLOCK(8)) u_dut8  (.clk(clk), .rst(rst), .bus(b8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // One beat into the idle 16-bit pipeline; lat = cycles from accept edge to out_valid (0 = timeout).
  task automatic run16(input logic [15:0] ta, input logic [15:0] tbv, input logic tc, input logic ts,
                       output logic [15:0] rs, output logic rc, output logic ro, output int lat);
    rs = '0; rc = 1'b0; ro = 1'b0; lat = 0;
    @(posedge clk); #1;
    b16.in_valid = 1'b1; b16.a = ta; b16.b = tbv; b16.cin = tc; b16.sub = ts; b16.out_ready = 1'b1;
    @(posedge clk); #1;
    b16.in_valid = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (b16.out_valid === 1'b1) begin
        lat = n; rs = b16.sum; rc = b16.cout; ro = b16.ovf;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    b16.in_valid = 1'b0; b16.a = '0; b16.b = '0; b16.cin = 1'b0; b16.sub = 1'b0; b16.out_ready = 1'b1;
    b8.in_valid  = 1'b0; b8.a  = '0; b8.b  = '0; b8.cin  = 1'b0; b8.sub  = 1'b0; b8.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b want=0", b16.out_valid); end
    total++; if (b16.sum !== 16'h0000) begin bad++; $display("FAIL rst_sum got=%h want=0000", b16.sum); end
    total++; if ({b16.cout, b16.ovf} !== 2'b00) begin bad++; $display("FAIL rst_cout_ovf got=%b want=00", {b16.cout, b16.ovf}); end
    total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid8 got=%b want=0", b8.out_valid); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", b16.in_ready); end
    total++; if (b8.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready8 got=%b want=1", b8.in_ready); end
  endtask

  task automatic test_carry_wrap();
    logic [15:0] s; logic c, o; int lat;
    run16(16'hFFFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL wrap_latency got=%0d want=4", lat); end
    total++; if (s !== 16'h0000) begin bad++; $display("FAIL wrap_sum got=%h want=0000", s); end
    total++; if (c !== 1'b1) begin bad++; $display("FAIL wrap_cout got=%b want=1", c); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL wrap_ovf got=%b want=0", o); end
  endtask

  task automatic test_subtract();
    logic [15:0] s; logic c, o; int lat;
    run16(16'h0005, 16'h0007, 1'b1, 1'b1, s, c, o, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL sub_latency got=%0d want=4", lat); end
    total++; if (s !== 16'hFFFE) begin bad++; $display("FAIL sub_sum got=%h want=fffe", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL sub_cout got=%b want=0", c); end
    total++; if (o !== 1'b0) begin bad++; $display("FAIL sub_ovf got=%b want=0", o); end
  endtask

  task automatic test_overflow();
    logic [15:0] s; logic c, o; int lat;
    run16(16'h7FFF, 16'h0001, 1'b0, 1'b0, s, c, o, lat);
    total++; if (s !== 16'h8000) begin bad++; $display("FAIL ovf_sum got=%h want=8000", s); end
    total++; if (c !== 1'b0) begin bad++; $display("FAIL ovf_cout got=%b want=0", c); end
    total++; if (o !== OVF_ON) begin bad++; $display("FAIL ovf_flag got=%b want=%b", o, OVF_ON); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] es [3];
    logic        ec [3];
    logic        eo [3];
    logic        exp_rdy, acc, xfer;
    int          bi, oi;
    va[0] = 16'h0001; vb[0] = 16'h0002; es[0] = 16'h0003; ec[0] = 1'b0; eo[0] = 1'b0;
    va[1] = 16'h0003; vb[1] = 16'h0004; es[1] = 16'h0007; ec[1] = 1'b0; eo[1] = 1'b0;
    va[2] = 16'h8000; vb[2] = 16'h8000; es[2] = 16'h0000; ec[2] = 1'b1; eo[2] = OVF_ON;
    bi = 0; oi = 0;
    @(posedge clk); #1;
    for (int n = 0; n < 14; n++) begin
      b16.in_valid  = (bi < 3);
      b16.a         = (bi < 3) ? va[bi] : 16'h0000;
      b16.b         = (bi < 3) ? vb[bi] : 16'h0000;
      b16.cin       = 1'b0;
      b16.sub       = 1'b0;
      b16.out_ready = !((n == 4) || (n == 5));
      @(negedge clk);
      exp_rdy = !((n == 4) || (n == 5));
      total++; if (b16.in_ready !== exp_rdy) begin bad++; $display("FAIL b2b_in_ready cyc=%0d got=%b want=%b", n, b16.in_ready, exp_rdy); end
      if (n == 5) begin
        total++; if ({b16.out_valid, b16.sum} !== {1'b1, 16'h0003}) begin bad++; $display("FAIL b2b_hold got=%b/%h want=1/0003", b16.out_valid, b16.sum); end
      end
      acc  = b16.in_valid & b16.in_ready;
      xfer = b16.out_valid & b16.out_ready;
      if (xfer === 1'b1) begin
        total++;
        if (oi >= 3) begin
          bad++; $display("FAIL b2b_extra cyc=%0d got=%h want=none", n, b16.sum);
        end else if ({b16.sum, b16.cout, b16.ovf} !== {es[oi], ec[oi], eo[oi]}) begin
          bad++; $display("FAIL b2b_result%0d got=%h/%b/%b want=%h/%b/%b", oi, b16.sum, b16.cout, b16.ovf, es[oi], ec[oi], eo[oi]);
        end
        oi++;
      end
      @(posedge clk); #1;
      if (acc === 1'b1) bi++;
    end
    b16.in_valid = 1'b0; b16.out_ready = 1'b1;
    total++; if (bi !== 3) begin bad++; $display("FAIL b2b_accepted got=%0d want=3", bi); end
    total++; if (oi !== 3) begin bad++; $display("FAIL b2b_results got=%0d want=3", oi); end
  endtask

  task automatic test_reset_midflight();
    logic [15:0] s; logic c, o; int lat;
    @(posedge clk); #1;
    b16.out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      b16.in_valid = 1'b1; b16.a = 16'h1111 * (n + 1); b16.b = 16'h0101; b16.cin = 1'b0; b16.sub = 1'b0;
      @(posedge clk); #1;
    end
    b16.in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (b16.out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid got=%b want=1", b16.out_valid); end
    #2 rst = 1'b1;
    #1;
    total++; if ({b16.out_valid, b16.sum, b16.cout} !== 18'h0) begin bad++; $display("FAIL mid_async_clear got=%b/%h/%b want=0/0000/0", b16.out_valid, b16.sum, b16.cout); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      total++; if (b16.out_valid !== 1'b0) begin bad++; $display("FAIL mid_stale cyc=%0d got=%b want=0", n, b16.out_valid); end
    end
    total++; if (b16.in_ready !== 1'b1) begin bad++; $display("FAIL mid_in_ready got=%b want=1", b16.in_ready); end
    run16(16'h0010, 16'h0020, 1'b0, 1'b0, s, c, o, lat);
    total++; if (lat !== 4) begin bad++; $display("FAIL mid_latency got=%0d want=4", lat); end
    total++; if (s !== 16'h0030) begin bad++; $display("FAIL mid_sum got=%h want=0030", s); end
  endtask

  task automatic test_single_stage();
    int lat;
    lat = 0;
    @(posedge clk); #1;
    b8.in_valid = 1'b1; b8.a = 8'hAA; b8.b = 8'h55; b8.cin = 1'b1; b8.sub = 1'b0; b8.out_ready = 1'b1;
    @(posedge clk); #1;
    b8.in_valid = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (b8.out_valid === 1'b1) begin lat = n; break; end
    end
    total++; if (lat !== 1) begin bad++; $display("FAIL s1_latency got=%0d want=1", lat); end
    total++; if (b8.sum !== 8'h00) begin bad++; $display("FAIL s1_sum got=%h want=00", b8.sum); end
    total++; if (b8.cout !== 1'b1) begin bad++; $display("FAIL s1_cout got=%b want=1", b8.cout); end
    total++; if (b8.ovf !== 1'b0) begin bad++; $display("FAIL s1_ovf got=%b want=0", b8.ovf); end
    @(negedge clk);
    total++; if (b8.out_valid !== 1'b0) begin bad++; $display("FAIL s1_once got=%b want=0", b8.out_valid); end
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_subtract();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    test_single_stage();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
